// File: rtl/seg7_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_mux
// Purpose  : Multi-channel hex scanner for a common-anode 7-segment bank with
//            frame snapshots, leading-zero blanking and decimal points.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_mux #(
   parameter int CH_NUM   = 2,
   parameter int CH_W     = 16,
   parameter int SCAN_DIV = 100000
) (
   input  logic                        clk_100MHz_i,
   input  logic                        rst_n,
   input  logic                        en_i,
   input  logic [CH_NUM*CH_W-1:0]      cnt_val_i,
   input  logic [CH_NUM-1:0]           blank_lz_i,
   input  logic [CH_NUM*CH_W/4-1:0]    dp_mask_i,
   output logic [7:0]                  HEX_o,
   output logic [CH_NUM*CH_W/4-1:0]    AN_o,
   output logic                        frame_o
);

   localparam int DIGITS        = CH_NUM * CH_W / 4;
   localparam int c_nib_per_ch  = CH_W / 4;
   localparam int c_idx_w       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int c_presc_w     = $clog2(SCAN_DIV);

   logic [c_presc_w-1:0]    r_presc;
   logic [c_idx_w-1:0]      r_idx;
   logic [CH_NUM*CH_W-1:0]  r_snap;

   logic                    w_tick;
   logic                    w_wrap;
   logic [DIGITS-1:0]       w_blank;
   logic [DIGITS-1:0]       w_an_n;
   logic [3:0]              w_nibs [DIGITS];
   logic [6:0]              w_seg;

   function automatic logic [6:0] hex_decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   // Channels are packed nibble-contiguous, so digit d is simply nibble d of snap.
   for (genvar d = 0; d < DIGITS; d++) begin : g_digit
      localparam int c_ch  = d / c_nib_per_ch;
      localparam int c_nib = d % c_nib_per_ch;

      assign w_nibs[d] = r_snap[4*d +: 4];
      assign w_an_n[d] = (r_idx != c_idx_w'(d));

      if (c_nib == 0) begin : g_lsn
         assign w_blank[d] = 1'b0;
      end else begin : g_upper
         assign w_blank[d] = blank_lz_i[c_ch] &&
            (r_snap[c_ch*CH_W + 4*c_nib +: CH_W - 4*c_nib] == '0);
      end
   end

   assign w_tick = en_i && (r_presc == c_presc_w'(SCAN_DIV - 1));
   assign w_wrap = w_tick && (r_idx == c_idx_w'(DIGITS - 1));
   assign w_seg  = w_blank[r_idx] ? 7'h7F : hex_decode(w_nibs[r_idx]);

   always_ff @(posedge clk_100MHz_i or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_idx   <= '0;
         r_snap  <= '0;
      end else if (!en_i) begin
         r_presc <= '0;
         r_idx   <= '0;
         r_snap  <= cnt_val_i;
      end else begin
         if (w_tick) begin
            r_presc <= '0;
            r_idx   <= w_wrap ? '0 : r_idx + 1'b1;
         end else begin
            r_presc <= r_presc + 1'b1;
         end
         if (w_wrap) begin
            r_snap <= cnt_val_i;
         end
      end
   end

   // Outputs lag idx/snap by one cycle; disabled display is fully dark.
   always_ff @(posedge clk_100MHz_i or negedge rst_n) begin
      if (!rst_n) begin
         AN_o    <= '1;
         HEX_o   <= 8'hFF;
         frame_o <= 1'b0;
      end else if (!en_i) begin
         AN_o    <= '1;
         HEX_o   <= 8'hFF;
         frame_o <= 1'b0;
      end else begin
         AN_o    <= w_an_n;
         HEX_o   <= {~dp_mask_i[r_idx], w_seg};
         frame_o <= w_wrap;
      end
   end

endmodule
`default_nettype wire
